// File: rtl/trace_pkg.sv
// Shared types and constants for the retirement-trace transmitter.
package trace_pkg;

    localparam int TRACE_DEPTH_DEF = 4;
    localparam int TRACE_ORDER_W   = 32;
    localparam int TRACE_XLEN      = 32;

    typedef struct packed {
        logic [TRACE_ORDER_W-1:0] order;
        logic [TRACE_XLEN-1:0]    pc;
        logic [31:0]              instr;
        logic [4:0]               rd;
        logic                     rd_we;
        logic [TRACE_XLEN-1:0]    rd_wdata;
        logic                     mem_we;
        logic [TRACE_XLEN-1:0]    mem_addr;
        logic [TRACE_XLEN-1:0]    mem_wdata;
    } trace_rec_t;

endpackage

// File: rtl/commit_trace_tx_if.sv
// Retire-side and trace-stream signals of commit_trace_tx.
// slave = transmitter view, master = core/consumer view.
interface commit_trace_tx_if
    import trace_pkg::*;
#(
    parameter int XLEN = TRACE_XLEN
) ();

    logic            i_ret_valid;
    logic [XLEN-1:0] i_ret_pc;
    logic [31:0]     i_ret_instr;
    logic [4:0]      i_ret_rd;
    logic            i_ret_rd_we;
    logic [XLEN-1:0] i_ret_rd_wdata;
    logic            i_ret_mem_we;
    logic [XLEN-1:0] i_ret_mem_addr;
    logic [XLEN-1:0] i_ret_mem_wdata;
    logic            o_stall;

    logic            o_trc_valid;
    logic            i_trc_ready;
    logic [31:0]     o_trc_order;
    logic [XLEN-1:0] o_trc_pc;
    logic [31:0]     o_trc_instr;
    logic [4:0]      o_trc_rd;
    logic            o_trc_rd_we;
    logic [XLEN-1:0] o_trc_rd_wdata;
    logic            o_trc_mem_we;
    logic [XLEN-1:0] o_trc_mem_addr;
    logic [XLEN-1:0] o_trc_mem_wdata;
    logic            o_overflow;

    modport slave (
        input  i_ret_valid, i_ret_pc, i_ret_instr, i_ret_rd, i_ret_rd_we,
               i_ret_rd_wdata, i_ret_mem_we, i_ret_mem_addr, i_ret_mem_wdata,
               i_trc_ready,
        output o_stall, o_trc_valid, o_trc_order, o_trc_pc, o_trc_instr,
               o_trc_rd, o_trc_rd_we, o_trc_rd_wdata, o_trc_mem_we,
               o_trc_mem_addr, o_trc_mem_wdata, o_overflow
    );

    modport master (
        output i_ret_valid, i_ret_pc, i_ret_instr, i_ret_rd, i_ret_rd_we,
               i_ret_rd_wdata, i_ret_mem_we, i_ret_mem_addr, i_ret_mem_wdata,
               i_trc_ready,
        input  o_stall, o_trc_valid, o_trc_order, o_trc_pc, o_trc_instr,
               o_trc_rd, o_trc_rd_we, o_trc_rd_wdata, o_trc_mem_we,
               o_trc_mem_addr, o_trc_mem_wdata, o_overflow
    );

endinterface

// File: rtl/trace_fifo.sv
// Synchronous FIFO of trace records; registered storage, no fall-through.
// Pointers wrap naturally; a separate count register tells full from empty.
module trace_fifo
    import trace_pkg::*;
#(
    parameter int DEPTH = TRACE_DEPTH_DEF
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_push,
    input  trace_rec_t                 i_data,
    input  logic                       i_pop,
    output trace_rec_t                 o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    trace_rec_t       r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    // An illegal push or pop request is ignored rather than corrupting state.
    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);

    // Record storage
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers and occupancy
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1'b1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1'b1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1'b1);
                2'b01:   r_count <= r_count - CNT_W'(1'b1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == CNT_W'(1'b0));
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];

endmodule

// File: rtl/commit_trace_tx.sv
// Retirement-trace transmitter: captures, masks and sequence-tags retiring
// instructions into a FIFO. Define TRACE_STALL_EN to drive o_stall when full.
module commit_trace_tx
    import trace_pkg::*;
#(
    parameter int DEPTH = TRACE_DEPTH_DEF,
    parameter int XLEN  = TRACE_XLEN
) (
    input  logic                i_clk,
    input  logic                i_rst,
    commit_trace_tx_if.slave    bus
);

    logic [TRACE_ORDER_W-1:0] r_order;
    logic                     r_overflow;
    trace_rec_t               w_cap;
    trace_rec_t               w_head;
    trace_rec_t               w_out;
    logic                     w_full;
    logic                     w_empty;
    logic [$clog2(DEPTH):0]   w_count;
    logic                     w_push;
    logic                     w_pop;
    logic                     w_drop;

    // Build the record, zeroing effects that did not architecturally happen
    always_comb begin
        w_cap       = '0;
        w_cap.order = r_order;
        w_cap.pc    = bus.i_ret_pc;
        w_cap.instr = bus.i_ret_instr;
        w_cap.rd    = bus.i_ret_rd;
        if (bus.i_ret_rd != 5'd0) begin
            w_cap.rd_we    = bus.i_ret_rd_we;
            w_cap.rd_wdata = bus.i_ret_rd_wdata;
        end else begin
            w_cap.rd_we    = 1'b0;
            w_cap.rd_wdata = {XLEN{1'b0}};
        end
        if (bus.i_ret_mem_we) begin
            w_cap.mem_we    = 1'b1;
            w_cap.mem_addr  = bus.i_ret_mem_addr;
            w_cap.mem_wdata = bus.i_ret_mem_wdata;
        end else begin
            w_cap.mem_we    = 1'b0;
            w_cap.mem_addr  = {XLEN{1'b0}};
            w_cap.mem_wdata = {XLEN{1'b0}};
        end
    end

    assign w_pop  = !w_empty && bus.i_trc_ready;
    assign w_push = bus.i_ret_valid && (!w_full || w_pop);
    assign w_drop = bus.i_ret_valid && w_full && !w_pop;

    trace_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_data  (w_cap),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Retire counter advances on dropped records too, so gaps expose drops
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_order <= '0;
        end else if (bus.i_ret_valid) begin
            r_order <= r_order + TRACE_ORDER_W'(1'b1);
        end
    end

    // Sticky drop indicator
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

`ifdef TRACE_STALL_EN
    assign bus.o_stall = (w_count == ($clog2(DEPTH)+1)'(DEPTH));
`else
    logic w_unused_count;
    assign w_unused_count = ^w_count;
    assign bus.o_stall    = 1'b0;
`endif

    assign w_out = w_empty ? '0 : w_head;

    assign bus.o_trc_valid     = !w_empty;
    assign bus.o_trc_order     = w_out.order;
    assign bus.o_trc_pc        = w_out.pc;
    assign bus.o_trc_instr     = w_out.instr;
    assign bus.o_trc_rd        = w_out.rd;
    assign bus.o_trc_rd_we     = w_out.rd_we;
    assign bus.o_trc_rd_wdata  = w_out.rd_wdata;
    assign bus.o_trc_mem_we    = w_out.mem_we;
    assign bus.o_trc_mem_addr  = w_out.mem_addr;
    assign bus.o_trc_mem_wdata = w_out.mem_wdata;
    assign bus.o_overflow      = r_overflow;

endmodule

// File: tb/tb_commit_trace_tx.sv
// Directed self-checking bench for commit_trace_tx (DEPTH=4, XLEN=32).
module tb_commit_trace_tx;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

`ifdef TRACE_STALL_EN
    localparam logic STALL_EXP = 1'b1;
`else
    localparam logic STALL_EXP = 1'b0;
`endif

    always #5 clk = ~clk;

    commit_trace_tx_if #(.XLEN(32)) bus ();

    commit_trace_tx #(
        .DEPTH (4),
        .XLEN  (32)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ret(input logic [31:0] pc, input logic [31:0] instr,
                       input logic [4:0] rd, input logic rd_we, input logic [31:0] wdata,
                       input logic mem_we, input logic [31:0] addr, input logic [31:0] mdata);
        bus.i_ret_valid     = 1'b1;
        bus.i_ret_pc        = pc;
        bus.i_ret_instr     = instr;
        bus.i_ret_rd        = rd;
        bus.i_ret_rd_we     = rd_we;
        bus.i_ret_rd_wdata  = wdata;
        bus.i_ret_mem_we    = mem_we;
        bus.i_ret_mem_addr  = addr;
        bus.i_ret_mem_wdata = mdata;
    endtask

    task automatic ret_simple(input logic [31:0] pc);
        ret(pc, 32'h0000_0013, 5'd1, 1'b1, pc, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic idle();
        bus.i_ret_valid = 1'b0;
    endtask

    initial begin
        idle();
        ret(32'h0, 32'h0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        idle();
        bus.i_trc_ready = 1'b1;

        // Reset state
        step();
        step();
        chk("rst_valid", bus.o_trc_valid, 1'b0);
        chk("rst_stall", bus.o_stall, 1'b0);
        chk("rst_ovf", bus.o_overflow, 1'b0);
        chk("rst_order", bus.o_trc_order, 32'h0);
        chk("rst_pc", bus.o_trc_pc, 32'h0);
        rst = 1'b0;

        // addi x5,x0,7 at pc 0
        ret(32'h0, 32'h0070_0293, 5'd5, 1'b1, 32'd7, 1'b0, 32'h0, 32'h0);
        step();
        idle();
        chk("addi_valid", bus.o_trc_valid, 1'b1);
        chk("addi_order", bus.o_trc_order, 32'd0);
        chk("addi_instr", bus.o_trc_instr, 32'h0070_0293);
        chk("addi_rd", bus.o_trc_rd, 5'd5);
        chk("addi_rd_we", bus.o_trc_rd_we, 1'b1);
        chk("addi_wdata", bus.o_trc_rd_wdata, 32'd7);
        step();

        // rd=0 and mem_we=0 masking
        ret(32'h4, 32'h0000_0013, 5'd0, 1'b1, 32'h1234, 1'b0, 32'h55, 32'h66);
        step();
        idle();
        chk("x0_valid", bus.o_trc_valid, 1'b1);
        chk("x0_order", bus.o_trc_order, 32'd1);
        chk("x0_rd_we", bus.o_trc_rd_we, 1'b0);
        chk("x0_wdata", bus.o_trc_rd_wdata, 32'h0);
        chk("x0_maddr", bus.o_trc_mem_addr, 32'h0);
        chk("x0_mdata", bus.o_trc_mem_wdata, 32'h0);
        step();

        // sw x6,0x100(x0) storing 0xDEADBEEF
        ret(32'h8, 32'h1060_2023, 5'd0, 1'b0, 32'h0, 1'b1, 32'h100, 32'hDEAD_BEEF);
        step();
        idle();
        chk("sw_order", bus.o_trc_order, 32'd2);
        chk("sw_mem_we", bus.o_trc_mem_we, 1'b1);
        chk("sw_maddr", bus.o_trc_mem_addr, 32'h100);
        chk("sw_mdata", bus.o_trc_mem_wdata, 32'hDEAD_BEEF);
        chk("sw_rd_we", bus.o_trc_rd_we, 1'b0);
        step();
        chk("drain_valid", bus.o_trc_valid, 1'b0);
        chk("drain_pc_zero", bus.o_trc_pc, 32'h0);

        // Mid-stream reset with 3 queued records
        bus.i_trc_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ret_simple(32'h200 + 32'(4 * i));
            step();
        end
        idle();
        chk("q3_valid", bus.o_trc_valid, 1'b1);
        chk("q3_order", bus.o_trc_order, 32'd3);
        rst = 1'b1;
        #1;
        chk("arst_valid", bus.o_trc_valid, 1'b0);
        chk("arst_pc", bus.o_trc_pc, 32'h0);
        chk("arst_ovf", bus.o_overflow, 1'b0);
        step();
        rst = 1'b0;

        // Fill to DEPTH, then push and pop together
        for (int i = 0; i < 4; i++) begin
            ret_simple(32'h1000 + 32'(4 * i));
            step();
        end
        idle();
        chk("full_stall", bus.o_stall, STALL_EXP);
        chk("full_order", bus.o_trc_order, 32'd0);
        chk("full_pc", bus.o_trc_pc, 32'h1000);
        chk("full_ovf", bus.o_overflow, 1'b0);
        bus.i_trc_ready = 1'b1;
        ret_simple(32'h2000);
        step();
        chk("pp1_order", bus.o_trc_order, 32'd1);
        chk("pp1_stall", bus.o_stall, STALL_EXP);
        ret_simple(32'h2004);
        step();
        idle();
        chk("pp2_order", bus.o_trc_order, 32'd2);
        chk("pp2_stall", bus.o_stall, STALL_EXP);
        chk("pp2_ovf", bus.o_overflow, 1'b0);

        // Retire into a full FIFO without a pop: dropped, order 6 lost
        bus.i_trc_ready = 1'b0;
        ret_simple(32'h3000);
        step();
        idle();
        chk("drop_ovf", bus.o_overflow, 1'b1);
        chk("drop_head", bus.o_trc_order, 32'd2);
        chk("drop_hold_pc", bus.o_trc_pc, 32'h1008);

        // Drain and observe the gap
        bus.i_trc_ready = 1'b1;
        step();
        chk("dr_order3", bus.o_trc_order, 32'd3);
        step();
        chk("dr_order4", bus.o_trc_order, 32'd4);
        chk("dr_pc4", bus.o_trc_pc, 32'h2000);
        step();
        chk("dr_order5", bus.o_trc_order, 32'd5);
        ret_simple(32'h4000);
        step();
        idle();
        chk("gap_order7", bus.o_trc_order, 32'd7);
        chk("gap_pc", bus.o_trc_pc, 32'h4000);
        step();
        chk("end_valid", bus.o_trc_valid, 1'b0);
        chk("end_stall", bus.o_stall, 1'b0);
        chk("end_ovf_sticky", bus.o_overflow, 1'b1);
        chk("end_order_zero", bus.o_trc_order, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
